// File: rtl/mixer_n_ch.sv
// N-channel pipelined audio mixer: per-channel gain and mute, a registered binary adder
// tree, and a left-justified mix output with an optional average mode and peak tracking.
module mixer_n_ch #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 8,
  parameter int GAIN_W = 4,
  parameter int OUT_W  = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   in_valid,
  input  logic [NUM_CH*IN_W-1:0]                 audio_in,
  input  logic [NUM_CH*GAIN_W-1:0]               gain,
  input  logic [NUM_CH-1:0]                      mute,
  input  logic                                   avg_mode,
  input  logic                                   peak_clr,
  output logic [OUT_W-1:0]                       mix_down,
  output logic                                   out_valid,
  output logic [IN_W+GAIN_W+$clog2(NUM_CH)-1:0]  peak
);

  localparam int LG = $clog2(NUM_CH);
  localparam int S  = IN_W + GAIN_W + LG;

  // Input capture registers: in_valid sampled at edge t reaches out_valid after edge t+LG+2.
  logic                       r_in_vld;
  logic [NUM_CH*IN_W-1:0]     r_in_audio;
  logic [NUM_CH*GAIN_W-1:0]   r_in_gain;
  logic [NUM_CH-1:0]          r_in_mute;
  logic                       r_in_avg;

  // Heap-ordered tree: node i sums nodes 2i and 2i+1; leaves NUM_CH..2*NUM_CH-1 hold the
  // gained products, node 1 holds the full sum. Depth d valid/avg bits follow the data.
  logic [S-1:0] r_node [1:2*NUM_CH-1];
  logic [LG:0]  r_lv;
  logic [LG:0]  r_avg;

  logic [S-1:0]     w_sum;
  logic [S-1:0]     w_res;
  logic [OUT_W-1:0] w_mix;
  logic [S-1:0]     w_peak_next;

  assign w_sum = r_node[1];
  assign w_res = r_avg[0] ? (w_sum >> LG) : w_sum;
  assign w_mix = OUT_W'(w_res) << (OUT_W - S);

  always_comb begin
    // NOTE: default first so every path assigns w_peak_next and no latch is inferred.
    w_peak_next = peak;
    if (r_lv[0]) begin
      if (peak_clr || (w_sum > peak)) w_peak_next = w_sum;
    end else if (peak_clr) begin
      w_peak_next = '0;
    end
  end

  // Control and output state: reset clears every valid bit so in-flight samples are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_vld  <= 1'b0;
      r_lv      <= '0;
      out_valid <= 1'b0;
      mix_down  <= '0;
      peak      <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage reads the previous stage's old value.
      r_in_vld  <= in_valid;
      r_lv      <= {r_in_vld, r_lv[LG:1]};
      out_valid <= r_lv[0];
      if (r_lv[0]) mix_down <= w_mix;
      peak      <= w_peak_next;
    end
  end

  // NOTE: datapath registers carry no reset; they load only under their valid bit, and the
  // reset valid bits keep any stale contents from ever reaching the outputs.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_in_audio <= audio_in;
      r_in_gain  <= gain;
      r_in_mute  <= mute;
      r_in_avg   <= avg_mode;
    end
    if (r_in_vld) begin
      r_avg[LG] <= r_in_avg;
      for (int k = 0; k < NUM_CH; k++) begin
        r_node[NUM_CH+k] <= r_in_mute[k] ? '0
                          : S'(r_in_audio[k*IN_W +: IN_W]) * S'(r_in_gain[k*GAIN_W +: GAIN_W]);
      end
    end
    for (int d = 0; d < LG; d++) begin
      if (r_lv[d+1]) begin
        r_avg[d] <= r_avg[d+1];
        for (int i = (1 << d); i < (2 << d); i++) begin
          r_node[i] <= r_node[2*i] + r_node[2*i+1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mixer_n_ch.sv
// Self-checking bench for mixer_n_ch: directed scenarios plus a random phase, all compared
// each cycle against a sample-queue reference model of the mixer.
module tb_mixer_n_ch;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 8;
  localparam int GAIN_W = 4;
  localparam int OUT_W  = 32;
  localparam int LG     = 2;
  localparam int S      = 14;
  localparam int L      = 4;

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic                     in_valid = 1'b0;
  logic [NUM_CH*IN_W-1:0]   audio_in = '0;
  logic [NUM_CH*GAIN_W-1:0] gain = '0;
  logic [NUM_CH-1:0]        mute = '0;
  logic                     avg_mode = 1'b0;
  logic                     peak_clr = 1'b0;
  logic [OUT_W-1:0]         mix_down;
  logic                     out_valid;
  logic [S-1:0]             peak;

  mixer_n_ch #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .audio_in(audio_in), .gain(gain),
    .mute(mute), .avg_mode(avg_mode), .peak_clr(peak_clr), .mix_down(mix_down),
    .out_valid(out_valid), .peak(peak)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int sum;
    bit avg;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          model_peak = 0;
  logic [31:0] model_mix = '0;

  function automatic int ref_sum(logic [31:0] a, logic [15:0] g, logic [3:0] m);
    int s = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (!m[k]) s += int'(a[k*IN_W +: IN_W]) * int'(g[k*GAIN_W +: GAIN_W]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock: update the model with what the DUT samples at this edge, then compare.
  task automatic step();
    exp_t e;
    int   r;
    bit   exp_ov;
    @(posedge clk);
    cyc++;
    exp_ov = 1'b0;
    if (resetn) begin
      if (in_valid)
        q.push_back('{due: cyc + L, sum: ref_sum(audio_in, gain, mute), avg: avg_mode});
      if (q.size() > 0 && q[0].due == cyc) begin
        e         = q.pop_front();
        exp_ov    = 1'b1;
        r         = e.avg ? (e.sum / NUM_CH) : e.sum;
        model_mix = 32'(r) * (32'd1 << (OUT_W - S));
        model_peak = (peak_clr || e.sum > model_peak) ? e.sum : model_peak;
      end else if (peak_clr) begin
        model_peak = 0;
      end
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    check("mix_down", mix_down, model_mix);
    check("peak", {18'b0, peak}, 32'(model_peak));
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [15:0] g,
                       input logic [3:0] m, input logic avg);
    in_valid = v;
    audio_in = a;
    gain     = g;
    mute     = m;
    avg_mode = avg;
  endtask

  task automatic single_sample(input logic [31:0] a, input logic [15:0] g,
                               input logic [3:0] m, input logic avg);
    drive(1'b1, a, g, m, avg);
    step();
    in_valid = 1'b0;
    repeat (L) step();
  endtask

  initial begin
    #2;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_mix_down", mix_down, 32'd0);
    check("reset_peak", {18'b0, peak}, 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    step();

    // Unity gains, sum mode: 100 left-justified.
    single_sample({8'd40, 8'd30, 8'd20, 8'd10}, 16'h1111, 4'b0000, 1'b0);
    check("t1_mix_const", mix_down, 32'h0190_0000);
    step();

    // Same stimulus averaged: floor(100/4) = 25, peak stays at the full sum 100.
    single_sample({8'd40, 8'd30, 8'd20, 8'd10}, 16'h1111, 4'b0000, 1'b1);
    check("t2_mix_const", mix_down, 32'h0064_0000);
    check("t2_peak_const", {18'b0, peak}, 32'd100);
    step();

    // Full-scale input: 4*255*15 = 15300 fits in 14 bits.
    single_sample(32'hFFFF_FFFF, 16'hFFFF, 4'b0000, 1'b0);
    check("t3_mix_const", mix_down, 32'hEF10_0000);
    check("t3_peak_const", {18'b0, peak}, 32'd15300);
    step();

    // Back-to-back ramp with channel 1 muted, a 2-cycle bubble, then two more samples.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {8'(i*10+3), 8'(i*10+2), 8'(i*10+1), 8'(i*10)}, 16'h1111, 4'b0010, 1'b0);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, {8'(200+i), 8'd99, 8'd7, 8'd5}, 16'h2131, 4'b0010, 1'b0);
      step();
    end
    in_valid = 1'b0;
    repeat (L + 1) step();

    // Peak tracking: clear alone, then sums 100, 300, 200.
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("t5_clr_alone_a", {18'b0, peak}, 32'd0);
    drive(1'b1, {8'd0, 8'd0, 8'd0, 8'd100}, 16'h0001, 4'b0000, 1'b0);
    step();
    drive(1'b1, {8'd0, 8'd0, 8'd0, 8'd150}, 16'h0002, 4'b0000, 1'b0);
    step();
    drive(1'b1, {8'd0, 8'd0, 8'd0, 8'd200}, 16'h0001, 4'b0000, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (L + 1) step();
    check("t5_peak_300", {18'b0, peak}, 32'd300);
    // Clear coinciding with a valid sum of 50 at the output stage.
    drive(1'b1, {8'd0, 8'd0, 8'd25, 8'd25}, 16'h0011, 4'b0000, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (L - 1) step();
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("t5_peak_clr_valid", {18'b0, peak}, 32'd50);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("t5_clr_alone_b", {18'b0, peak}, 32'd0);

    // Reset with three samples in flight; nothing may emerge after release.
    single_sample({8'd1, 8'd2, 8'd3, 8'd4}, 16'h1111, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {8'(50+i), 8'd60, 8'd70, 8'd80}, 16'h3333, 4'b0000, 1'b0);
      step();
    end
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_mix_down", mix_down, 32'd0);
    check("t6_rst_peak", {18'b0, peak}, 32'd0);
    q.delete();
    model_mix  = '0;
    model_peak = 0;
    repeat (2) step();
    resetn = 1'b1;
    repeat (8) step();
    single_sample({8'd9, 8'd8, 8'd7, 8'd6}, 16'h1111, 4'b0000, 1'b0);
    check("t6_new_out_valid", {31'b0, out_valid}, 32'd1);
    check("t6_new_mix", mix_down, 32'd30 << (OUT_W - S));
    step();

    // Random phase.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom(), 16'($urandom()), 4'($urandom()),
            1'($urandom()));
      peak_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0;
    peak_clr = 1'b0;
    repeat (L + 2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
